disp_wave_render: RTL and testbench



---
 rtl/disp_wave_render.sv | 107 ++++++++++
 tb/tb_disp_wave_render.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/disp_wave_render.sv
// Scrolling audio waveform pixel source with a double-buffered sample RAM.
// Define WAVE_GRID_EN to build the grid overlay (trace still drawn on top).
`ifndef Red_Bits
`define Red_Bits 5
`endif
`ifndef Green_Bits
`define Green_Bits 6
`endif
`ifndef Blue_Bits
`define Blue_Bits 5
`endif

module disp_wave_render #(
  parameter int H_DISP    = 800,
  parameter int V_DISP    = 480,
  parameter int ADDR_W    = 10,
  parameter int THICK     = 1,
  parameter int GRID_STEP = 64,
  parameter logic [`Red_Bits+`Green_Bits+`Blue_Bits-1:0] WAVE_COLOR = 16'h07E0,
  parameter logic [`Red_Bits+`Green_Bits+`Blue_Bits-1:0] BG_COLOR   = 16'h0000,
  parameter logic [`Red_Bits+`Green_Bits+`Blue_Bits-1:0] GRID_COLOR = 16'h4208
) (
  input  logic              ClkDisp,
  input  logic              Rst_n,
  input  logic              Wr_En,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [7:0]        Wr_Data,
  input  logic              Wr_Done,
  output logic              Wr_Ready,
  input  logic              DataReq,
  input  logic [11:0]       H_Addr,
  input  logic [11:0]       V_Addr,
  input  logic              Frame_Begin,
  output logic [`Red_Bits+`Green_Bits+`Blue_Bits-1:0] Data
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic signed [12:0] THK = 13'(THICK);
  localparam logic signed [12:0] Y_MID = 13'(V_DISP / 2);

  typedef enum logic {FILL, COMMITTED} bank_st_e;

  bank_st_e          st;
  logic              front_sel, valid;
  logic [7:0]        bank0 [DEPTH];
  logic [7:0]        bank1 [DEPTH];
  logic [7:0]        sample_q;
  logic              wr_ok;
  logic [ADDR_W-1:0] rd_next;
  logic signed [12:0] y_wave, dy;
  logic              hit, grid;

  assign wr_ok   = Wr_En && Wr_Ready && ({1'b0, Wr_Addr} < (ADDR_W+1)'(H_DISP));
  assign rd_next = DataReq ? ADDR_W'(H_Addr + 12'd1) : '0;

  // Frame_Begin sees the registered state, so a same-cycle Wr_Done waits a frame.
  always_ff @(posedge ClkDisp or posedge Rst_n)
    if (Rst_n) begin
      st        <= FILL;
      front_sel <= 1'b0;
      valid     <= 1'b0;
      Wr_Ready  <= 1'b1;
    end else begin
      case (st)
        FILL: if (Wr_Done) begin
          st       <= COMMITTED;
          Wr_Ready <= 1'b0;
        end
        COMMITTED: if (Frame_Begin) begin
          st        <= FILL;
          front_sel <= ~front_sel;
          valid     <= 1'b1;
          Wr_Ready  <= 1'b1;
        end
        default: st <= FILL;
      endcase
    end

  always_ff @(posedge ClkDisp) begin
    if (wr_ok && front_sel)  bank0[Wr_Addr] <= Wr_Data;
    if (wr_ok && !front_sel) bank1[Wr_Addr] <= Wr_Data;
  end

  // Prefetch column H_Addr+1 (or 0 in blanking) so Data needs no extra latency.
  always_ff @(posedge ClkDisp or posedge Rst_n)
    if (Rst_n) sample_q <= '0;
    else       sample_q <= front_sel ? bank1[rd_next] : bank0[rd_next];

  assign y_wave = Y_MID - {{5{sample_q[7]}}, sample_q};
  assign dy     = $signed({1'b0, V_Addr}) - y_wave;
  assign hit    = (dy <= THK) && (dy >= -THK);

`ifdef WAVE_GRID_EN
  localparam int GB = $clog2(GRID_STEP);
  assign grid = (H_Addr[GB-1:0] == '0) || (V_Addr[GB-1:0] == '0) ||
                (V_Addr == 12'(V_DISP / 2));
`else
  assign grid = 1'b0;
`endif

  always_comb begin
    Data = BG_COLOR;
    if (DataReq && valid) begin
      if (hit)       Data = WAVE_COLOR;
      else if (grid) Data = GRID_COLOR;
    end
  end
endmodule

// File: tb/tb_disp_wave_render.sv
// Scoreboard bench for disp_wave_render: random samples, reduced frames, bank-swap model.
`ifndef Red_Bits
`define Red_Bits 5
`endif
`ifndef Green_Bits
`define Green_Bits 6
`endif
`ifndef Blue_Bits
`define Blue_Bits 5
`endif

module tb_disp_wave_render;
  localparam int HD = 800;

  logic        ClkDisp = 1'b0, Rst_n = 1'b1;
  logic        Wr_En = 1'b0, Wr_Done = 1'b0, DataReq = 1'b0, Frame_Begin = 1'b0;
  logic [9:0]  Wr_Addr = '0;
  logic [7:0]  Wr_Data = '0;
  logic [11:0] H_Addr = '0, V_Addr = '0;
  logic        Wr_Ready;
  logic [`Red_Bits+`Green_Bits+`Blue_Bits-1:0] Data;

  always #5 ClkDisp = ~ClkDisp;

  disp_wave_render dut (
    .ClkDisp(ClkDisp), .Rst_n(Rst_n), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr),
    .Wr_Data(Wr_Data), .Wr_Done(Wr_Done), .Wr_Ready(Wr_Ready), .DataReq(DataReq),
    .H_Addr(H_Addr), .V_Addr(V_Addr), .Frame_Begin(Frame_Begin), .Data(Data));

  typedef struct {logic [15:0] data; logic ready; int h; int v;} exp_t;
  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;

  // Reference: two banks of signed samples, the displayed bank, commit flag, valid.
  int mb [2][1024];
  int m_front = 0;
  bit m_pend = 0, m_valid = 0;
  int lq[$];

  function automatic logic [15:0] exp_pix(bit req, int h, int v);
    int y;
    if (!req || !m_valid) return 16'h0000;
    y = 240 - mb[m_front][h];
    if (v - y <= 1 && y - v <= 1) return 16'h07E0;
`ifdef WAVE_GRID_EN
    if (h % 64 == 0 || v % 64 == 0 || v == 240) return 16'h4208;
`endif
    return 16'h0000;
  endfunction

  task automatic step(bit req, int h, int v, bit we, int wa, int wd, bit done, bit fb, bit rst);
    exp_t e;
    DataReq = req; H_Addr = 12'(h); V_Addr = 12'(v);
    Wr_En = we; Wr_Addr = 10'(wa); Wr_Data = 8'(wd);
    Wr_Done = done; Frame_Begin = fb; Rst_n = rst;
    if (rst) begin m_front = 0; m_pend = 0; m_valid = 0; end
    e.data = exp_pix(req, h, v); e.ready = !m_pend; e.h = h; e.v = v;
    exp_q.push_back(e);
    @(posedge ClkDisp);
    if (!rst) begin
      if (we && !m_pend && wa < HD) mb[1 - m_front][wa] = wd;
      if (fb && m_pend) begin m_front = 1 - m_front; m_pend = 0; m_valid = 1; end
      else if (done && !m_pend) m_pend = 1;
    end
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write_all(bit rnd);
    for (int x = 0; x < HD; x++)
      step(0, 0, 0, 1, x, rnd ? int'($urandom_range(0, 255)) - 128 : 0, 0, 0, 0);
  endtask

  task automatic add_trace(int bank, int n);
    int c, y;
    repeat (n) begin
      c = $urandom_range(0, HD - 1);
      y = 240 - mb[bank][c];
      lq.push_back(y - 1); lq.push_back(y + 1);
    end
    lq.push_back($urandom_range(0, 479));
  endtask

  task automatic frame(bit done_fb);
    step(0, 0, 0, 0, 0, 0, done_fb, 1, 0);
    idle(3);
    foreach (lq[i]) begin
      idle(2);
      for (int x = 0; x < HD; x++) step(1, x, lq[i], 0, 0, 0, 0, 0, 0);
    end
    idle(2);
    lq = {};
  endtask

  always @(negedge ClkDisp) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests += 2;
      if (Data !== e.data) begin
        n_fail++;
        $display("FAIL data h=%0d v=%0d got=%h exp=%h", e.h, e.v, Data, e.data);
      end
      if (Wr_Ready !== e.ready) begin
        n_fail++;
        $display("FAIL wr_ready t=%0t got=%b exp=%b", $time, Wr_Ready, e.ready);
      end
    end
  end

  initial begin
    @(posedge ClkDisp); #1;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Nothing committed: background only, ready stays high
    lq = {0, 240, 479}; frame(0);
    lq = {100}; frame(0);

    // Flat zero trace into bank 1
    write_all(0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);
    lq = {0, 100, 238, 239, 240, 241, 242, 479}; frame(0);

    // Random trace into bank 0 with extreme samples at the edges
    write_all(1);
    step(0, 0, 0, 1, 0, 127, 0, 0, 0);
    step(0, 0, 0, 1, 799, -128, 0, 0, 0);
    step(0, 0, 0, 1, 900, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    lq = {112, 113, 114, 115, 366, 367, 368, 369}; add_trace(0, 2); frame(0);

    // Wr_Done together with Frame_Begin: swap deferred one frame
    write_all(1);
    lq = {}; add_trace(0, 2); frame(1);
    step(0, 0, 0, 1, 10, 50, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    lq = {189, 190, 191, 239 - mb[1][10], 241 - mb[1][10]}; add_trace(1, 1); frame(0);

    // Reset in the middle of a line: background until next commit+swap
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    for (int x = 0; x < HD; x++)
      step(1, x, 240 - mb[1][x], 0, 0, 0, 0, 0, (x >= 400 && x < 403));
    idle(2);
    lq = {}; add_trace(1, 2); frame(0);
    write_all(1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    lq = {}; add_trace(1, 3); frame(0);

    repeat (4) @(posedge ClkDisp);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
